// File: rtl/riscv_pkg.sv
// Shared front-end types: fetch FSM states and the {pc, instr} queue entry.
package riscv_pkg;

    localparam int XLEN = 32;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with a flush input; head is read straight from the array.
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         push,
    input  fetch_entry_t                 push_data,
    input  logic                         pop,
    output fetch_entry_t                 head,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    fetch_entry_t    mem_reg [DEPTH];
    logic [AW-1:0]   wr_ptr_reg;
    logic [AW-1:0]   rd_ptr_reg;
    logic [CW-1:0]   count_reg;
    logic            wr_en;
    logic            rd_en;

    // A push into a full FIFO is only accepted when the head leaves in the same cycle.
    assign rd_en = pop && (count_reg != '0);
    assign wr_en = push && ((count_reg != CW'(DEPTH)) || rd_en);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (wr_en) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (rd_en) rd_ptr_reg <= rd_ptr_reg + AW'(1);
            count_reg <= count_reg + CW'(wr_en) - CW'(rd_en);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_reg[wr_ptr_reg] <= push_data;
    end

    assign head  = mem_reg[rd_ptr_reg];
    assign count = count_reg;

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch front end: issues sequential fetches, queues in-order responses,
// and drains stale responses after a control-flow redirect.
module fetch_queue
    import riscv_pkg::*;
#(
    parameter int              XLEN     = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              DEPTH    = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            fetch_en,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            req_valid,
    input  logic            req_ready,
    output logic [XLEN-1:0] req_addr,
    input  logic            resp_valid,
    input  logic [XLEN-1:0] resp_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_pc_plus_4,
    output logic [XLEN-1:0] out_instr
);

    localparam int          CW        = $clog2(DEPTH+1);
    localparam logic [CW:0] DEPTH_EXT = (CW+1)'(DEPTH);

    fetch_state_t    state_reg, state_next;
    logic [XLEN-1:0] fetch_pc_reg;
    logic [XLEN-1:0] resp_pc_reg;
    logic [XLEN-1:0] redirect_target;
    logic [CW-1:0]   outstanding_reg, outstanding_next;
    logic [CW-1:0]   count;
    logic [CW:0]     in_flight;
    logic            req_fire, resp_dec, push, pop;
    fetch_entry_t    head, push_entry;

    // Entries already queued plus those still in memory must fit, so a response is never refused.
    assign in_flight = {1'b0, count} + {1'b0, outstanding_reg};
    assign req_valid = !rst && (state_reg == RUN) && fetch_en && !redirect_valid
                       && (in_flight < DEPTH_EXT);
    assign req_addr  = fetch_pc_reg;
    assign req_fire  = req_valid && req_ready;
    assign resp_dec  = resp_valid && (outstanding_reg != '0);
    assign outstanding_next = outstanding_reg + CW'(req_fire) - CW'(resp_dec);

    assign out_valid = !rst && (count != '0);
    assign push      = (state_reg == RUN) && !redirect_valid && resp_valid;
    assign pop       = out_valid && out_ready && !redirect_valid;

    assign redirect_target  = redirect_pc & ~XLEN'(3);
    assign push_entry.pc    = resp_pc_reg;
    assign push_entry.instr = resp_data;

    fetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

    always_comb begin
        state_next = state_reg;
        if (redirect_valid) begin
            state_next = (outstanding_next != '0) ? DRAIN : RUN;
        end else if (state_reg == DRAIN) begin
            state_next = (outstanding_next == '0) ? RUN : DRAIN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= RUN;
            fetch_pc_reg    <= RESET_PC;
            resp_pc_reg     <= RESET_PC;
            outstanding_reg <= '0;
        end else begin
            state_reg       <= state_next;
            outstanding_reg <= outstanding_next;
            if (redirect_valid) begin
                fetch_pc_reg <= redirect_target;
                resp_pc_reg  <= redirect_target;
            end else begin
                if (req_fire) fetch_pc_reg <= fetch_pc_reg + XLEN'(4);
                if (push)     resp_pc_reg  <= resp_pc_reg + XLEN'(4);
            end
        end
    end

    assign out_pc        = head.pc;
    assign out_instr     = head.instr;
    assign out_pc_plus_4 = head.pc + XLEN'(4);

endmodule

// File: tb/tb_fetch_queue.sv
// Randomised and directed checks of fetch_queue against a queue-based behavioural model.
module tb_fetch_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_en = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        req_valid;
    logic        req_ready = 1'b0;
    logic [31:0] req_addr;
    logic        resp_valid = 1'b0;
    logic [31:0] resp_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [31:0] out_pc_plus_4;
    logic [31:0] out_instr;

    fetch_queue dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_addr       (req_addr),
        .resp_valid     (resp_valid),
        .resp_data      (resp_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_pc_plus_4  (out_pc_plus_4),
        .out_instr      (out_instr)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    bit verbose  = 1'b1;
    bit spurious = 1'b0;

    // Behavioural model: queue contents, fetch/response PCs, in-flight count, drain flag.
    logic [31:0] mq_pc[$];
    logic [31:0] mq_instr[$];
    logic [31:0] m_fetch_pc, m_resp_pc;
    int          m_out;
    bit          m_drain;

    // Memory: pending addresses in order with the cycle they were accepted.
    logic [31:0] mem_addr[$];
    int          mem_issue[$];

    logic [31:0] req_log[$];
    logic [31:0] out_log[$];
    logic [31:0] out_p4_log[$];
    logic        s_req_valid, s_out_valid;
    logic [31:0] s_req_addr;

    function automatic logic [31:0] mem_word(logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        mq_pc.delete();
        mq_instr.delete();
        mem_addr.delete();
        mem_issue.delete();
        m_fetch_pc = 32'h0;
        m_resp_pc  = 32'h0;
        m_out      = 0;
        m_drain    = 1'b0;
    endtask

    // Called just after the falling edge with inputs applied; checks, updates model, advances one cycle.
    task automatic cycle();
        bit e_req, e_out, req_fire, pop;
        int new_out;
        #1;
        s_req_valid = req_valid;
        s_req_addr  = req_addr;
        s_out_valid = out_valid;
        if (rst) begin
            chk("rst_req_valid", {31'b0, req_valid}, 32'd0);
            chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
            model_reset();
        end else begin
            e_req = !m_drain && fetch_en && !redirect_valid && (mq_pc.size() + m_out < DEPTH);
            e_out = mq_pc.size() != 0;
            chk("req_valid", {31'b0, req_valid}, {31'b0, e_req});
            chk("out_valid", {31'b0, out_valid}, {31'b0, e_out});
            if (e_req) chk("req_addr", req_addr, m_fetch_pc);
            if (e_out) begin
                chk("out_pc", out_pc, mq_pc[0]);
                chk("out_pc_plus_4", out_pc_plus_4, mq_pc[0] + 32'd4);
                chk("out_instr", out_instr, mq_instr[0]);
            end
            if (req_valid && req_ready) req_log.push_back(req_addr);
            if (out_valid && out_ready && !redirect_valid) begin
                out_log.push_back(out_pc);
                out_p4_log.push_back(out_pc_plus_4);
                if (verbose) $display("cycle %0d: decode takes pc=%h instr=%h", cyc, out_pc, out_instr);
            end

            req_fire = e_req && req_ready;
            pop      = e_out && out_ready;
            if (resp_valid && !spurious) begin
                void'(mem_addr.pop_front());
                void'(mem_issue.pop_front());
            end
            if (req_fire) begin
                mem_addr.push_back(m_fetch_pc);
                mem_issue.push_back(cyc);
            end
            new_out = m_out + (req_fire ? 1 : 0) - ((resp_valid && m_out > 0) ? 1 : 0);

            if (redirect_valid) begin
                mq_pc.delete();
                mq_instr.delete();
                m_fetch_pc = {redirect_pc[31:2], 2'b00};
                m_resp_pc  = {redirect_pc[31:2], 2'b00};
                m_drain    = new_out != 0;
            end else begin
                if (pop) begin
                    void'(mq_pc.pop_front());
                    void'(mq_instr.pop_front());
                end
                if (m_drain) begin
                    m_drain = new_out != 0;
                end else begin
                    if (resp_valid) begin
                        if (mq_pc.size() < DEPTH) begin
                            mq_pc.push_back(m_resp_pc);
                            mq_instr.push_back(resp_data);
                        end
                        m_resp_pc = m_resp_pc + 32'd4;
                    end
                    if (req_fire) m_fetch_pc = m_fetch_pc + 32'd4;
                end
            end
            m_out = new_out;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic drive(bit fe, bit rr, bit rsp, bit ordy, bit rd, logic [31:0] rpc, bit r);
        fetch_en       = fe;
        req_ready      = rr;
        out_ready      = ordy;
        redirect_valid = rd;
        redirect_pc    = rpc;
        rst            = r;
        spurious       = 1'b0;
        if (rsp && mem_addr.size() > 0 && mem_issue[0] < cyc) begin
            resp_valid = 1'b1;
            resp_data  = mem_word(mem_addr[0]);
        end else begin
            resp_valid = 1'b0;
            resp_data  = $urandom;
        end
        cycle();
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 0, 1);
        req_log.delete();
        out_log.delete();
        out_p4_log.delete();
    endtask

    initial begin
        model_reset();
        @(negedge clk);

        // Streaming with a 1-cycle memory: sequential addresses, in-order output.
        do_reset();
        for (int i = 0; i < 12; i++) drive(1, 1, 1, 1, 0, 0, 0);
        chk("seq_addr0", req_log[0], 32'h0);
        chk("seq_addr1", req_log[1], 32'h4);
        chk("seq_addr2", req_log[2], 32'h8);
        chk("seq_out_pc0", out_log[0], 32'h0);
        chk("seq_out_p4_0", out_p4_log[0], 32'h4);
        chk("seq_out_pc1", out_log[1], 32'h4);

        // Backpressure: exactly DEPTH requests, then resume.
        do_reset();
        for (int i = 0; i < 12; i++) drive(1, 1, 1, 0, 0, 0, 0);
        chk("bp_req_count", req_log.size(), 32'd4);
        chk("bp_req_valid_low", {31'b0, s_req_valid}, 32'd0);
        for (int i = 0; i < 5; i++) drive(1, 1, 1, 1, 0, 0, 0);
        chk("bp_resumed", {31'b0, req_log.size() > 4}, 32'd1);

        // Redirect with 3 outstanding: drain, then fetch from 0x100.
        do_reset();
        for (int i = 0; i < 3; i++) drive(1, 1, 0, 0, 0, 0, 0);
        drive(1, 1, 0, 1, 1, 32'h100, 0);
        req_log.delete();
        out_log.delete();
        drive(1, 1, 1, 1, 0, 0, 0);
        chk("drain_req_low", {31'b0, s_req_valid}, 32'd0);
        for (int i = 0; i < 8; i++) drive(1, 1, 1, 1, 0, 0, 0);
        chk("drain_next_addr", req_log[0], 32'h100);
        chk("drain_first_out", out_log[0], 32'h100);

        // Redirect to unaligned 0x203 with a same-cycle response and decode handshake.
        do_reset();
        drive(1, 1, 0, 0, 0, 0, 0);
        drive(0, 1, 1, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 0, 0, 0);
        out_log.delete();
        drive(1, 1, 1, 1, 1, 32'h203, 0);
        chk("rd203_out_taken", out_log.size(), 32'd0);
        drive(1, 0, 0, 0, 0, 0, 0);
        chk("rd203_empty", {31'b0, s_out_valid}, 32'd0);
        chk("rd203_req_valid", {31'b0, s_req_valid}, 32'd1);
        chk("rd203_req_addr", s_req_addr, 32'h200);

        // Full queue: push and pop in one cycle keep four entries in order.
        do_reset();
        for (int i = 0; i < 10; i++) drive(1, 1, 1, 0, 0, 0, 0);
        out_log.delete();
        fetch_en = 0; req_ready = 0; out_ready = 1; redirect_valid = 0; rst = 0;
        resp_valid = 1; resp_data = 32'hDEAD_BEEF; spurious = 1'b1;
        cycle();
        spurious = 1'b0;
        chk("full_still_valid", {31'b0, s_out_valid}, 32'd1);
        for (int i = 0; i < 5; i++) drive(0, 0, 0, 1, 0, 0, 0);
        chk("full_out_count", out_log.size(), 32'd5);
        chk("full_order0", out_log[0], 32'h0);
        chk("full_order3", out_log[3], 32'hC);
        chk("full_order4", out_log[4], 32'h10);

        // Second redirect during DRAIN.
        do_reset();
        for (int i = 0; i < 3; i++) drive(1, 1, 0, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 1, 32'h100, 0);
        drive(1, 1, 1, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 1, 32'h40, 0);
        req_log.delete();
        drive(1, 1, 1, 1, 0, 0, 0);
        chk("rd2_still_drain", {31'b0, s_req_valid}, 32'd0);
        for (int i = 0; i < 8; i++) drive(1, 1, 1, 1, 0, 0, 0);
        chk("rd2_next_addr", req_log[0], 32'h40);

        // Random traffic.
        verbose = 1'b0;
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            drive($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6,
                  $urandom_range(0, 9) < 6, $urandom_range(0, 99) < 3, $urandom,
                  $urandom_range(0, 999) < 3);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter XLEN, default riscv_pkg::XLEN (32), address/data width.
REQ-002 SHALL have parameter RESET_PC, default 0, first fetch address after reset.
REQ-003 SHALL have parameter DEPTH, default 4, queue entries; power of two, >=2.
REQ-004 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port fetch_en  input  1  permits new memory requests when high.
REQ-007 SHALL have port redirect_valid  input  1  control-flow redirect (pre-prioritised upstream).
REQ-008 SHALL have port redirect_pc  input  XLEN  redirect target.
REQ-009 SHALL have port req_valid  output  1  memory fetch request.
REQ-010 SHALL have port req_ready  input  1  memory accepts request.
REQ-011 SHALL have port req_addr  output  XLEN  fetch address.
REQ-012 SHALL have port resp_valid  input  1  in-order instruction return, any latency >=1.
REQ-013 SHALL have port resp_data  input  XLEN  returned instruction word.
REQ-014 SHALL have port out_valid  output  1  queue head valid to decode.
REQ-015 SHALL have port out_ready  input  1  decode accepts head.
REQ-016 SHALL have port out_pc  output  XLEN  PC of head instruction.
REQ-017 SHALL have port out_pc_plus_4  output  XLEN  out_pc + 4, modulo 2^XLEN.
REQ-018 SHALL have port out_instr  output  XLEN  head instruction word.

Function
REQ-019 SHALL implement FSM states RUN and DRAIN; req handshake = req_valid&&req_ready; out handshake = out_valid&&out_ready.
REQ-020 SHALL drive req_valid = (state==RUN) && fetch_en && !redirect_valid && (count+outstanding < DEPTH), guaranteeing queue space for every response.
REQ-021 SHALL drive req_addr = fetch_pc; fetch_pc += 4 (wrapping) on each req handshake.
REQ-022 SHALL track outstanding (width clog2(DEPTH+1)): +1 on req handshake, -1 on resp_valid, both same cycle = unchanged.
REQ-023 SHALL, in RUN without redirect, push {resp_pc, resp_data} on resp_valid and advance resp_pc by 4; entry visible on out_* next cycle (1-cycle latency).
REQ-024 SHALL drive out_valid = count!=0; simultaneous push and pop when full or empty SHALL both take effect.
REQ-025 SHALL, on redirect_valid (any state): flush queue (count 0 next cycle), load fetch_pc and resp_pc with {redirect_pc[XLEN-1:2],2'b00}, discard any same-cycle resp_valid and out handshake.
REQ-026 SHALL, on redirect, enter DRAIN if outstanding after this cycle's update is nonzero, else RUN.
REQ-027 SHALL, in DRAIN, issue no requests and discard every response; return to RUN the cycle after outstanding reaches 0.
REQ-028 SHALL treat a req handshake in the redirect cycle as impossible (req_valid low); a redirect in DRAIN reloads PCs and stays in DRAIN.
REQ-029 SHALL hold req_addr stable while req_valid && !req_ready except on redirect.
REQ-030 SHALL stop issuing when fetch_en low without disturbing outstanding responses or queue.

Reset
REQ-031 SHALL, on rst, set state RUN, fetch_pc=resp_pc=RESET_PC, outstanding=0, count=0.
REQ-032 SHALL present req_valid=0 and out_valid=0 in the reset cycle; reset mid-transaction abandons outstanding responses (memory reset together).

Structure
REQ-033 SHALL place fetch_state_t enum and fetch_entry_t struct {pc, instr} in riscv_pkg; XLEN from riscv_pkg.
REQ-034 SHALL instantiate one sub-module fetch_fifo (synchronous FIFO, DEPTH x fetch_entry_t, flush input).

Verification
REQ-035 Reset, fetch_en=1, req_ready=1, 1-cycle memory -> addresses 0,4,8,... ; out_pc 0 with out_pc_plus_4 4, in order.
REQ-036 out_ready=0, DEPTH=4 -> exactly 4 req handshakes, then req_valid=0; out_ready=1 -> fetching resumes.
REQ-037 3 outstanding, redirect to 0x100 -> DRAIN, 3 responses dropped, next req_addr 0x100, first out_pc 0x100.
REQ-038 Redirect to 0x203 with same-cycle resp_valid and out handshake -> response dropped, queue empty, next req_addr 0x200.
REQ-039 Full queue with out_ready=1 and resp_valid=1 same cycle -> count stays 4, order preserved.
REQ-040 Second redirect to 0x40 while in DRAIN -> stays DRAIN until outstanding 0, then fetches 0x40.
